// File: rtl/sierpinski_ca_gen_pkg.sv
// Shared mode encodings, sizing constants and the seed function for the
// Sierpinski cellular-automaton generator.
package sierpinski_ca_gen_pkg;

  typedef enum logic [1:0] {
    ModeRule90  = 2'b00,
    ModeRule150 = 2'b01,
    ModeLfsr    = 2'b10,
    ModeHold    = 2'b11
  } mode_e;

  localparam int unsigned MaxWidth   = 64;
  localparam int unsigned CountWidth = 7;
  localparam int unsigned PrescWidth = 16;

  // Seed: a single live cell in the middle of the array (bit width/2).
  function automatic logic [MaxWidth-1:0] seed_fn(input int unsigned width);
    return {{(MaxWidth-1){1'b0}}, 1'b1} << (width / 2);
  endfunction

endpackage

// File: rtl/sierpinski_next_state.sv
// Combinational next-generation logic: rule 90, rule 150 and Galois LFSR.
module sierpinski_next_state
  import sierpinski_ca_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic [WIDTH-1:0] state_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [MaxWidth-1:0] SeedFull = seed_fn(WIDTH);
  localparam logic [WIDTH-1:0]    Seed     = SeedFull[WIDTH-1:0];

  // Bit i of nbr_lo is s[i-1], bit i of nbr_hi is s[i+1]; shifts supply the zero boundaries.
  logic [WIDTH-1:0] nbr_lo;
  logic [WIDTH-1:0] nbr_hi;

  assign nbr_lo = state_i << 1;
  assign nbr_hi = state_i >> 1;

  // Select the next generation for the requested mode.
  always_comb begin
    next_o = state_i;
    unique case (mode_i)
      ModeRule90:  next_o = nbr_lo ^ nbr_hi;
      ModeRule150: next_o = nbr_lo ^ state_i ^ nbr_hi;
      ModeLfsr: begin
        // All-zero is the LFSR lockup state; recover by reseeding.
        if (state_i == '0) begin
          next_o = Seed;
        end else begin
          next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);
        end
      end
      default:     next_o = state_i;
    endcase
  end

endmodule

// File: rtl/sierpinski_ca_gen.sv
// Sierpinski cellular-automaton / LFSR pattern generator with an 8-bit
// window readout, free-run prescaler, single-step and auto-reseed.
module sierpinski_ca_gen
  import sierpinski_ca_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      ROWS  = 16,
  parameter int unsigned      DIV   = 1,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [MaxWidth-1:0]   SeedFull  = seed_fn(WIDTH);
  localparam logic [WIDTH-1:0]      Seed      = SeedFull[WIDTH-1:0];
  localparam logic [CountWidth-1:0] LastRow   = CountWidth'(ROWS - 1);
  localparam logic [PrescWidth-1:0] LastPresc = PrescWidth'(DIV - 1);

  logic [WIDTH-1:0]      state_q, state_d;
  logic [CountWidth-1:0] row_q, row_d;
  logic [PrescWidth-1:0] presc_q, presc_d;
  logic                  wrap_q, wrap_d;
  logic                  step_prev_q, step_prev_d;
  mode_e                 mode_q, mode_d;

  mode_e            mode_in;
  logic             run, step_in, restart;
  logic [2:0]       win_sel;
  logic             step_pulse, presc_hit, mode_change, do_step;
  logic [WIDTH-1:0] next_state;
  logic [MaxWidth-1:0] state_ext;
  logic             unused_uio;

  assign mode_in = mode_e'(ui_in[1:0]);
  assign run     = ui_in[2];
  assign step_in = ui_in[3];
  assign restart = ui_in[4];
  assign win_sel = ui_in[7:5];

  assign step_pulse  = step_in & ~step_prev_q;
  assign presc_hit   = run && (presc_q == LastPresc);
  // Hold is transparent: compare only against the last non-hold mode.
  assign mode_change = (mode_in != ModeHold) && (mode_in != mode_q);
  assign do_step     = ena && (mode_in != ModeHold) && (presc_hit || step_pulse);

  sierpinski_next_state #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next_state (
    .state_i (state_q),
    .mode_i  (mode_in),
    .next_o  (next_state)
  );

  // Next-state: restart/mode-change reseed beats a step; CA steps count rows and auto-reseed.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    presc_d     = presc_q;
    wrap_d      = 1'b0;
    mode_d      = mode_q;
    step_prev_d = step_in;

    if (!run) begin
      presc_d = '0;
    end else if (ena) begin
      presc_d = presc_hit ? '0 : presc_q + 1'b1;
    end

    if (ena && (mode_in != ModeHold)) begin
      mode_d = mode_in;
    end

    if (ena && (restart || mode_change)) begin
      state_d = Seed;
      row_d   = '0;
      presc_d = '0;
    end else if (do_step) begin
      if (mode_in == ModeLfsr) begin
        state_d = next_state;
      end else if (row_q == LastRow) begin
        state_d = Seed;
        row_d   = '0;
        wrap_d  = 1'b1;
      end else begin
        state_d = next_state;
        row_d   = row_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset to the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= Seed;
      row_q       <= '0;
      presc_q     <= '0;
      wrap_q      <= 1'b0;
      step_prev_q <= 1'b0;
      mode_q      <= ModeRule90;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      presc_q     <= presc_d;
      wrap_q      <= wrap_d;
      step_prev_q <= step_prev_d;
      mode_q      <= mode_d;
    end
  end

  // Zero-padding to MaxWidth makes windows beyond WIDTH read as 8'h00.
  assign state_ext = MaxWidth'(state_q);

  // Window readout and status outputs.
  always_comb begin
    uo_out  = state_ext[{win_sel, 3'b000} +: 8];
    uio_out = {wrap_q, row_q};
    uio_oe  = 8'hFF;
  end

  assign unused_uio = ^uio_in;

endmodule

// File: doc/sierpinski_ca_gen.md
SIERPINSKI_CA_GEN -- requirements
Module: sierpinski_ca_gen

Interface
REQ-001 Parameter WIDTH, default 16, cell-array width; legal values are multiples of 8 from 8 to 64.
REQ-002 Parameter ROWS, default 16, number of CA steps before automatic reseed; legal range 2..128.
REQ-003 Parameter DIV, default 1, clock cycles per free-run step; legal range 1..65535.
REQ-004 Parameter TAPS, default 16'hB400, WIDTH-bit Galois LFSR tap mask.
REQ-005 clk  in  1  the single clock; all state updates occur on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous and active-low.
REQ-007 ena  in  1  design enable; when ena=0 no step, restart or prescaler advance shall occur.
REQ-008 ui_in  in  8  control: [1:0] mode (00 rule-90, 01 rule-150, 10 LFSR, 11 hold), [2] run, [3] step, [4] restart, [7:5] window select.
REQ-009 uo_out  out  8  selected 8-bit window of the state register.
REQ-010 uio_in  in  8  unused and ignored.
REQ-011 uio_out  out  8  {wrap pulse, row count[6:0]}.
REQ-012 uio_oe  out  8  constant 8'hFF.

Function
REQ-013 Seed value: a single 1 at bit WIDTH/2, all other bits 0.
REQ-014 Step enable: ena=1, mode!=11, and either (run=1 and the prescaler reaches DIV-1) or a step pulse.
REQ-015 Step pulse: ui_in[3]=1 at a rising edge while the registered previous ui_in[3] is 0; it yields exactly one step per low-to-high transition.
REQ-016 Prescaler: counts 0..DIV-1 while run=1 and ena=1, wraps to 0, and clears when run=0.
REQ-017 Rule 90: next[i] = s[i-1] XOR s[i+1], with out-of-range neighbours read as 0.
REQ-018 Rule 150: next[i] = s[i-1] XOR s[i] XOR s[i+1], with zero boundaries.
REQ-019 LFSR mode: right shift; if the old s[0]=1, XOR the shifted value with TAPS.
REQ-020 LFSR lockup: an all-zero state in LFSR mode shall load the seed on the next step.
REQ-021 The row counter increments on each step in the CA modes and holds in LFSR mode.
REQ-022 A step taken with row count = ROWS-1 shall load the seed and clear the count, and uio_out[7] shall be 1 for exactly that following cycle.
REQ-023 Restart (ui_in[4]=1 with ena=1) shall load the seed, clear the count and prescaler, and take priority over a step in the same cycle.
REQ-024 A change of the active mode among 00/01/10 shall reseed as in REQ-023; entering or leaving hold (11) shall not reseed, and the comparison shall be against the last non-hold mode.
REQ-025 uo_out = state[8w+7:8w], where w = ui_in[7:5]; uo_out shall be 8'h00 when 8w >= WIDTH; uo_out is combinational from the state and w.
REQ-026 The state shall change only on step, restart, mode change or reset; latency is one edge from the qualifying input.

Reset
REQ-027 rst_n=0 shall asynchronously set the state to the seed, and clear the row count, prescaler, wrap pulse, stored previous step and stored mode (to 00).
REQ-028 During reset with WIDTH=16: uo_out=8'h00 for w=0, uo_out=8'h01 for w=1, and uio_out=8'h00.

Structure
REQ-029 Mode encodings and the seed-function constants shall reside in a shared package/include used by both RTL and bench.
REQ-030 The next-state computation (rules 90/150 and LFSR) shall be a combinational sub-module named sierpinski_next_state, parametrised by WIDTH and TAPS.

Verification
REQ-031 Rule 90 (WIDTH=16, DIV=1): run=1, mode=00 -> window0/window1 after step 1 = 80/02, step 2 = 40/04, step 3 = A0/0A.
REQ-032 Rule 150: single step from the seed -> window0=8'h80, window1=8'h03.
REQ-033 LFSR: mode=10, 8 steps -> state 16'h0001; the 9th step -> 16'hB400.
REQ-034 Wrap (ROWS=16): 16 run steps in mode 00 -> state = seed, count=0, and uio_out[7] high for exactly one cycle.
REQ-035 Step with run=0, ui_in[3] held high for 5 cycles -> exactly one step; restart asserted in the same cycle as a step -> seed, with no step applied.
REQ-036 Assert rst_n low mid-run between clock edges -> outputs immediately take the REQ-028 values; mode change 00->11->00 -> no reseed.
